// File: rtl/spi_reg_bank_pkg.sv
// Shared types and helpers for the SPI register bank.
package spi_reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CMD       = 2'd1,
        DATA      = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall detect.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] warm_q;

    // Edges stay masked until the chain has refilled after reset, so a pin
    // that differs from RESET_LEVEL at release does not look like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = warm_q[SYNC_STAGES-1] &  sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign fall  = warm_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2] &  sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// Mode-0 SPI target exposing NUM_REGS x DATA_W registers with in-frame read-back.
module spi_reg_bank
    import spi_reg_bank_pkg::*;
#(
    parameter int                NUM_REGS    = 8,
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 7,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         COPI,
    input  logic                         SCLK,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FW  = frame_w(ADDR_W, DATA_W);
    localparam int BCW = $clog2(FW + 2);
    localparam logic [BCW-1:0]  CNT_CMD  = BCW'(ADDR_W);
    localparam logic [BCW-1:0]  CNT_FULL = BCW'(FW);
    localparam logic [BCW-1:0]  CNT_SAT  = BCW'(FW + 1);
    localparam logic [ADDR_W:0] NREGS    = (ADDR_W+1)'(NUM_REGS);

    logic copi_s, copi_rise, copi_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic unused_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_copi (
        .clk(clk), .rst(rst), .din(COPI), .level(copi_s), .rise(copi_rise), .fall(copi_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(SCLK), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .din(nCS), .level(ncs_s), .rise(ncs_rise), .fall(ncs_fall));

    assign unused_edges = ^{copi_rise, copi_fall, sclk_s};

    state_t                        state, state_nx;
    logic [BCW-1:0]                bit_cnt;
    logic [FW-1:0]                 shift_reg;
    logic [DATA_W-1:0]             shadow;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic                          cipo_q;

    logic frame_start, cnt_en, shift_en, cmd_done, tx_shift, frame_end;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (ncs_fall) state_nx = CMD;
            CMD:       if (ncs_rise) state_nx = IDLE;
                       else if (sclk_rise && bit_cnt == CNT_CMD) state_nx = DATA;
            DATA:      if (ncs_rise) state_nx = IDLE;
                       else if (sclk_rise && bit_cnt == CNT_FULL) state_nx = WAIT_HIGH;
            WAIT_HIGH: if (ncs_rise) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        frame_start = (state == IDLE) && ncs_fall;
        frame_end   = (state != IDLE) && ncs_rise;
        cnt_en      = (state != IDLE) && sclk_rise && !ncs_rise && (bit_cnt != CNT_SAT);
        shift_en    = ((state == CMD) || (state == DATA)) && sclk_rise && !ncs_rise
                      && (bit_cnt < CNT_FULL);
        cmd_done    = (state == CMD) && sclk_rise && !ncs_rise && (bit_cnt == CNT_CMD);
        tx_shift    = (state == DATA) && sclk_fall && !ncs_rise;
    end

    // Command word as it stands once the last address bit is sampled.
    logic [ADDR_W:0]   cmd_next;
    logic [DATA_W-1:0] rd_val;
    assign cmd_next = {shift_reg[ADDR_W-1:0], copi_s};

    always_comb begin
        rd_val = '0;
        if (cmd_next[ADDR_W] == RW_READ) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (cmd_next[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs[i];
        end
    end

    logic              fr_rw, fr_full, fr_in_range, wr_ok;
    logic [ADDR_W-1:0] fr_addr;
    logic [DATA_W-1:0] fr_data;
    assign fr_rw       = shift_reg[FW-1];
    assign fr_addr     = shift_reg[FW-2 -: ADDR_W];
    assign fr_data     = shift_reg[DATA_W-1:0];
    assign fr_full     = (bit_cnt == CNT_FULL);
    assign fr_in_range = ({1'b0, fr_addr} < NREGS);
    assign wr_ok       = frame_end && fr_full && fr_in_range && (fr_rw == RW_WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            shadow    <= '0;
            cipo_q    <= 1'b0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            regs      <= {NUM_REGS{RESET_VAL}};
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (frame_start) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
                shadow    <= '0;
            end
            if (cnt_en)   bit_cnt   <= bit_cnt + BCW'(1);
            if (shift_en) shift_reg <= {shift_reg[FW-2:0], copi_s};
            if (cmd_done)      shadow <= rd_val;
            else if (tx_shift) shadow <= shadow << 1;
            // Read data runs out once all DATA_W bits have been presented.
            if (tx_shift)           cipo_q <= (bit_cnt < CNT_FULL) ? shadow[DATA_W-1] : 1'b0;
            else if (state != DATA) cipo_q <= 1'b0;
            if (frame_end) begin
                wr_strobe <= wr_ok;
                frame_err <= !fr_full || !fr_in_range;
            end
            if (wr_ok) wr_addr <= fr_addr;
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_ok && fr_addr == ADDR_W'(i)) regs[i] <= fr_data;
        end
    end

    assign CIPO      = cipo_q;
    assign cipo_oe   = ~ncs_s;
    assign regs_flat = regs;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: default build plus a 16-bit/3-bit-address build.
module tb_spi_reg_bank;

    localparam int HP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  copi, sclk, ncs, cipo, cipo_oe, wr_strobe, frame_err;
    logic [63:0] flat0;
    logic [79:0] flat1;
    logic [6:0]  wa0;
    logic [2:0]  wa1;

    spi_reg_bank #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2), .RESET_VAL(8'h5A)) dut0 (
        .clk(clk), .rst(rst), .COPI(copi[0]), .SCLK(sclk[0]), .nCS(ncs[0]),
        .CIPO(cipo[0]), .cipo_oe(cipo_oe[0]), .regs_flat(flat0),
        .wr_strobe(wr_strobe[0]), .wr_addr(wa0), .frame_err(frame_err[0]));

    spi_reg_bank #(.NUM_REGS(5), .DATA_W(16), .ADDR_W(3), .SYNC_STAGES(3), .RESET_VAL(16'h1234)) dut1 (
        .clk(clk), .rst(rst), .COPI(copi[1]), .SCLK(sclk[1]), .nCS(ncs[1]),
        .CIPO(cipo[1]), .cipo_oe(cipo_oe[1]), .regs_flat(flat1),
        .wr_strobe(wr_strobe[1]), .wr_addr(wa1), .frame_err(frame_err[1]));

    int st [2];
    int er [2];
    initial begin st[0] = 0; st[1] = 0; er[0] = 0; er[1] = 0; end
    always @(posedge clk) begin
        if (wr_strobe[0]) st[0] <= st[0] + 1;
        if (wr_strobe[1]) st[1] <= st[1] + 1;
        if (frame_err[0]) er[0] <= er[0] + 1;
        if (frame_err[1]) er[1] <= er[1] + 1;
    end

    // Reference model: register contents and last committed write address.
    logic [15:0] m [2][8];
    int          m_wa [2];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m[0][i] = 16'h005A;
            m[1][i] = 16'h1234;
        end
        m_wa[0] = 0;
        m_wa[1] = 0;
    endtask

    function automatic logic [127:0] model_flat(input int w);
        logic [127:0] r;
        r = '0;
        if (w == 0) for (int i = 0; i < 8; i++) r[i*8 +: 8]   = m[0][i][7:0];
        else        for (int i = 0; i < 5; i++) r[i*16 +: 16] = m[1][i];
        return r;
    endfunction

    task automatic chk_state(input int w, input string tag);
        if (w == 0) begin
            chk({tag, "_regs"}, 128'(flat0), model_flat(0));
            chk({tag, "_wa"}, 128'(wa0), 128'(m_wa[0]));
        end else begin
            chk({tag, "_regs"}, 128'(flat1), model_flat(1));
            chk({tag, "_wa"}, 128'(wa1), 128'(m_wa[1]));
        end
    endtask

    task automatic send_bits(input int w, input int n, input logic [63:0] bits, output logic [63:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            copi[w] = bits[i];
            tick(HP);
            rx = {rx[62:0], cipo[w]};
            sclk[w] = 1'b1;
            tick(HP);
            sclk[w] = 1'b0;
        end
    endtask

    // One frame: delta < 0 drops trailing bits, delta > 0 appends random ones.
    task automatic xfer(input int w, input logic rw, input int addr, input logic [15:0] data,
                        input int delta, input string tag);
        int aw, dw, nr, n, st0, er0;
        logic [63:0] f, rx;
        logic full, inr, ok, bad;
        logic [15:0] exp_rd;
        aw = (w == 0) ? 7 : 3;
        dw = (w == 0) ? 8 : 16;
        nr = (w == 0) ? 8 : 5;
        n  = 1 + aw + dw + delta;
        f  = (64'(rw) << (aw + dw)) | (64'(addr) << dw) | 64'(data & 16'((32'd1 << dw) - 1));
        if (delta > 0) f = (f << delta) | (64'($urandom) & ((64'd1 << delta) - 1));
        if (delta < 0) f = f >> (-delta);
        full = (delta == 0);
        inr  = (addr < nr);
        ok   = full && inr && rw;
        bad  = !full || !inr;
        exp_rd = inr ? m[w][addr] : 16'h0;
        if (dw == 8) exp_rd = exp_rd & 16'h00FF;
        st0 = st[w];
        er0 = er[w];
        ncs[w] = 1'b0;
        tick(HP);
        chk({tag, "_oe_on"}, 128'(cipo_oe[w]), 128'(1));
        send_bits(w, n, f, rx);
        tick(HP);
        ncs[w] = 1'b1;
        tick(12);
        if (ok) begin
            m[w][addr] = data;
            m_wa[w] = addr;
        end
        chk({tag, "_strobe"}, 128'(st[w] - st0), 128'(ok));
        chk({tag, "_err"}, 128'(er[w] - er0), 128'(bad));
        chk({tag, "_oe_off"}, 128'(cipo_oe[w]), 128'(0));
        if (full) chk({tag, "_cipo"}, 128'(rx), rw ? 128'(0) : 128'(exp_rd));
        chk_state(w, tag);
    endtask

    initial begin
        logic [63:0] rx;
        int st0, er0;
        copi = '0;
        sclk = '0;
        ncs  = 2'b11;
        model_reset();
        tick(3);
        chk("rst_cipo", 128'(cipo), 128'(0));
        chk("rst_oe", 128'(cipo_oe), 128'(0));
        chk("rst_strobe", 128'(wr_strobe), 128'(0));
        chk("rst_err", 128'(frame_err), 128'(0));
        chk_state(0, "rst0");
        chk_state(1, "rst1");
        rst = 1'b0;
        tick(4);

        xfer(0, 1'b1, 3, 16'h00A5, 0, "wr3");
        xfer(0, 1'b1, 5, 16'h003C, 0, "wr5");
        xfer(0, 1'b0, 5, 16'h0000, 0, "rd5");
        xfer(0, 1'b1, 2, 16'h0077, -1, "short");
        xfer(0, 1'b1, 2, 16'h0077, 1, "long");
        xfer(0, 1'b1, 9, 16'h0011, 0, "oor_wr");
        xfer(0, 1'b0, 9, 16'h0000, 0, "oor_rd");

        // Reset in the middle of a write to addr 1, with nCS held low through release.
        ncs[0] = 1'b0;
        tick(HP);
        send_bits(0, 10, 64'h0000_0000_0000_0206, rx);
        rst = 1'b1;
        tick(2);
        model_reset();
        chk("mid_cipo", 128'(cipo), 128'(0));
        chk("mid_oe", 128'(cipo_oe), 128'(0));
        chk("mid_strobe", 128'(wr_strobe), 128'(0));
        chk("mid_err", 128'(frame_err), 128'(0));
        chk_state(0, "mid0");
        chk_state(1, "mid1");
        rst = 1'b0;
        tick(10);
        chk("held_oe", 128'(cipo_oe[0]), 128'(1));
        st0 = st[0];
        er0 = er[0];
        ncs[0] = 1'b1;
        tick(12);
        chk("held_strobe", 128'(st[0] - st0), 128'(0));
        chk("held_err", 128'(er[0] - er0), 128'(0));
        xfer(0, 1'b1, 1, 16'h00C3, 0, "post_rst");

        xfer(1, 1'b1, 4, 16'hBEEF, 0, "sw_wr4");
        xfer(1, 1'b0, 4, 16'h0000, 0, "sw_rd4");
        xfer(1, 1'b0, 6, 16'h0000, 0, "sw_oor_rd");

        for (int k = 0; k < 24; k++) begin
            int w, addr, delta, pick;
            w = int'($urandom_range(0, 1));
            addr = (w == 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 7));
            pick = int'($urandom_range(0, 9));
            delta = (pick < 6) ? 0 : (pick < 8) ? -int'($urandom_range(1, 3)) : int'($urandom_range(1, 2));
            xfer(w, 1'($urandom), addr, 16'($urandom), delta, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
